// File: rtl/olp_sched_pkg.sv
// Shared types and constants for the scale scheduler: FSM states, scale indices,
// size codes and one-hot mux selects (bit order 0=23x23, 1=19x19, 2=17x17).
package olp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_BURST  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SC_23 = 2'd0;
    localparam logic [1:0] SC_19 = 2'd1;
    localparam logic [1:0] SC_17 = 2'd2;

    localparam logic [1:0] SZ_23 = 2'd0;
    localparam logic [1:0] SZ_19 = 2'd1;
    localparam logic [1:0] SZ_17 = 2'd2;

    localparam logic [2:0] SEL_23 = 3'b001;
    localparam logic [2:0] SEL_19 = 3'b010;
    localparam logic [2:0] SEL_17 = 3'b100;

    function automatic logic [2:0] sc_onehot(input logic [1:0] idx);
        case (idx)
            SC_23:   return SEL_23;
            SC_19:   return SEL_19;
            SC_17:   return SEL_17;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] sc_size(input logic [1:0] idx);
        case (idx)
            SC_23:   return SZ_23;
            SC_19:   return SZ_19;
            SC_17:   return SZ_17;
            default: return SZ_23;
        endcase
    endfunction

endpackage

// File: rtl/olp_prio_pick.sv
// Combinational 3-way scale picker: aged non-empty FIFOs first, else lowest non-empty index.
// Zero latency; no backpressure (pure function of its inputs).
module olp_prio_pick
    import olp_sched_pkg::*;
(
    input  logic [2:0] i_empty,
    input  logic [2:0] i_aged,
    output logic [1:0] o_idx,
    output logic       o_vld
);

    logic [2:0] w_req;
    logic [2:0] w_aged_req;
    logic [2:0] w_cand;

    assign w_req      = ~i_empty;
    assign w_aged_req = w_req & i_aged;
    assign w_cand     = (|w_aged_req) ? w_aged_req : w_req;

    always_comb begin
        o_idx = SC_23;
        o_vld = 1'b0;
        if (w_cand[0]) begin
            o_idx = SC_23;
            o_vld = 1'b1;
        end else if (w_cand[1]) begin
            o_idx = SC_19;
            o_vld = 1'b1;
        end else if (w_cand[2]) begin
            o_idx = SC_17;
            o_vld = 1'b1;
        end
    end

endmodule

// File: rtl/olp_scale_sched.sv
// Shares one classifier between three window-scale FIFOs: burst reads, credit limit, frame finish.
// oRd is combinational from state; oRun_Implement lags it by 1 cycle; stalls on !iEngine_ready or no credit. Aging: OLP_SCHED_AGING_EN.
module olp_scale_sched
    import olp_sched_pkg::*;
#(
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 4,
`ifdef OLP_SCHED_AGING_EN
    parameter int AGE_LIMIT       = 64,
`endif
    parameter int CNT_W           = 16
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iStart,
    input  logic [2:0]       iEmpty,
    input  logic [2:0]       iEnd,
    input  logic             iEngine_ready,
    input  logic             iResult_valid,
    output logic [2:0]       oRd,
    output logic [2:0]       oSel_Mux,
    output logic [1:0]       oSize,
    output logic             oRun_Implement,
    output logic             oBusy,
    output logic             oFinish,
    output logic [CNT_W-1:0] oWin_count
);

    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam int OS_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(BURST_LEN);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);
    localparam logic [OS_W-1:0] OS_MAX  = OS_W'(MAX_OUTSTANDING);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_grant;
    logic [2:0]        r_sel;
    logic [1:0]        r_size;
    logic [BC_W-1:0]   r_burst_cnt;
    logic [OS_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]  r_win_count;
    logic [2:0]        r_end_seen;
    logic              r_run;

    logic [1:0]        w_pick_idx;
    logic              w_pick_vld;
    logic [2:0]        w_aged;
    logic              w_take;
    logic              w_rd_en;
    logic              w_ret;

    olp_prio_pick u_pick (
        .i_empty (iEmpty),
        .i_aged  (w_aged),
        .o_idx   (w_pick_idx),
        .o_vld   (w_pick_vld)
    );

    // A read needs data, a ready engine, a free credit and burst budget left.
    assign w_rd_en = (r_state == ST_BURST) && !iEmpty[r_grant] && iEngine_ready
                  && (r_outstanding < OS_MAX) && (r_burst_cnt < BC_MAX);
    assign w_ret   = iResult_valid && (r_outstanding != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_pick_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_BURST;
                end else if ((r_end_seen == 3'b111) && (r_outstanding == '0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_BURST: begin
                if ((w_rd_en && (r_burst_cnt == BC_LAST)) || (iEmpty[r_grant] && !w_rd_en)) begin
                    w_state_nxt = ST_SELECT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state       <= ST_IDLE;
            r_grant       <= SC_23;
            r_sel         <= 3'b000;
            r_size        <= 2'd0;
            r_burst_cnt   <= '0;
            r_outstanding <= '0;
            r_win_count   <= '0;
            r_end_seen    <= 3'b000;
            r_run         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_rd_en;

            if (r_state == ST_IDLE) begin
                // An end pulse arriving with the start pulse belongs to the new frame.
                if (iStart) begin
                    r_end_seen    <= iEnd;
                    r_outstanding <= '0;
                    r_win_count   <= '0;
                end
            end else begin
                r_end_seen <= r_end_seen | iEnd;
                case ({w_rd_en, w_ret})
                    2'b10:   r_outstanding <= r_outstanding + 1'b1;
                    2'b01:   r_outstanding <= r_outstanding - 1'b1;
                    default: r_outstanding <= r_outstanding;
                endcase
                if (w_rd_en && (r_win_count != '1)) begin
                    r_win_count <= r_win_count + 1'b1;
                end
            end

            // Select and size persist past the burst so in-flight data stays steered.
            if (w_take) begin
                r_grant     <= w_pick_idx;
                r_sel       <= sc_onehot(w_pick_idx);
                r_size      <= sc_size(w_pick_idx);
                r_burst_cnt <= '0;
            end else if (w_rd_en) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

`ifdef OLP_SCHED_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] r_age [3];

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int i = 0; i < 3; i++) begin
                r_age[i] <= '0;
            end
        end else if (r_state != ST_IDLE) begin
            for (int i = 0; i < 3; i++) begin
                if ((w_take && (w_pick_idx == 2'(i))) || ((r_state == ST_BURST) && (r_grant == 2'(i)))) begin
                    r_age[i] <= '0;
                end else if (!iEmpty[i] && (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_aged = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_aged[i] = (r_age[i] == AGE_MAX);
        end
    end
`else
    assign w_aged = 3'b000;
`endif

    assign oRd            = w_rd_en ? sc_onehot(r_grant) : 3'b000;
    assign oSel_Mux       = r_sel;
    assign oSize          = r_size;
    assign oRun_Implement = r_run;
    assign oBusy          = (r_state != ST_IDLE);
    assign oFinish        = (r_state == ST_DONE);
    assign oWin_count     = r_win_count;

endmodule
